// File: rtl/load_store_unit.sv
// RV32I load/store unit: handles one LOAD or STORE per request over a single-outstanding
// req/gnt/rvalid memory port. Computes byte enables, store lane replication, fault
// checks and load sign/zero extension.
module load_store_unit #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_store,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [4:0]        req_rd,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic [4:0]        rsp_rd,
   output logic              rsp_misaligned,
   output logic              rsp_illegal
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   logic [1:0]        state, state_nxt;
   logic              accept;
   logic              dec_illegal, dec_misaligned;
   logic [3:0]        dec_be;
   logic [XLEN-1:0]   dec_wdata;
   logic [XLEN-1:0]   load_shifted, load_ext;

   logic [ADDR_W-1:0] addr_word;
   logic [1:0]        addr_off;
   logic [2:0]        funct3_r;
   logic              is_store_r;
   logic [4:0]        rd_r;
   logic [3:0]        be_r;
   logic [XLEN-1:0]   wdata_r;
   logic [XLEN-1:0]   rdata_r;
   logic              illegal_r, misaligned_r;

   // Idle only while out of reset so nothing is offered as accepted during reset.
   assign req_ready = (state == IDLE) && rst_n;
   assign accept    = req_valid && req_ready;

   // Decode the incoming request: fault checks, byte enables and store lane replication.
   always_comb begin
      dec_illegal    = 1'b0;
      dec_misaligned = 1'b0;
      dec_be         = 4'b1111;
      dec_wdata      = req_wdata;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: dec_illegal = 1'b0;
         3'b100, 3'b101:         dec_illegal = req_is_store;  // no unsigned stores
         default:                dec_illegal = 1'b1;
      endcase
      case (req_funct3)
         3'b000, 3'b100: begin
            dec_be    = 4'b0001 << req_addr[1:0];
            dec_wdata = {(XLEN/8){req_wdata[7:0]}};
         end
         3'b001, 3'b101: begin
            dec_misaligned = req_addr[0];
            dec_be         = 4'b0011 << {req_addr[1], 1'b0};
            dec_wdata      = {(XLEN/16){req_wdata[15:0]}};
         end
         default: begin
            dec_misaligned = (req_addr[1:0] != 2'b00);
            dec_be         = 4'b1111;
            dec_wdata      = req_wdata;
         end
      endcase
      // Illegal takes priority: only one fault flag is ever reported.
      if (dec_illegal) dec_misaligned = 1'b0;
   end

   // Align the addressed lane to bit 0 and extend according to the captured funct3.
   always_comb begin
      load_shifted = mem_rdata >> {addr_off, 3'b000};
      case (funct3_r)
         3'b000:  load_ext = {{(XLEN-8){load_shifted[7]}}, load_shifted[7:0]};
         3'b001:  load_ext = {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
         3'b100:  load_ext = {{(XLEN-8){1'b0}}, load_shifted[7:0]};
         3'b101:  load_ext = {{(XLEN-16){1'b0}}, load_shifted[15:0]};
         default: load_ext = load_shifted;
      endcase
   end

   // Next-state logic for IDLE -> REQ -> (WAIT) -> RESP -> IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (dec_illegal || dec_misaligned) ? RESP : REQ;
         REQ:  if (mem_gnt) state_nxt = is_store_r ? RESP : WAIT;
         WAIT: if (mem_rvalid) state_nxt = RESP;
         RESP: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Capture the request on accept and the extended load data when it returns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_word    <= '0;
         addr_off     <= 2'b00;
         funct3_r     <= 3'b000;
         is_store_r   <= 1'b0;
         rd_r         <= 5'd0;
         be_r         <= 4'b0000;
         wdata_r      <= '0;
         rdata_r      <= '0;
         illegal_r    <= 1'b0;
         misaligned_r <= 1'b0;
      end else if (accept) begin
         addr_word    <= {req_addr[ADDR_W-1:2], 2'b00};
         addr_off     <= req_addr[1:0];
         funct3_r     <= req_funct3;
         is_store_r   <= req_is_store;
         rd_r         <= req_rd;
         be_r         <= dec_be;
         wdata_r      <= dec_wdata;
         rdata_r      <= '0;
         illegal_r    <= dec_illegal;
         misaligned_r <= dec_misaligned;
      end else if ((state == WAIT) && mem_rvalid) begin
         rdata_r <= load_ext;
      end
   end

   // Memory port is driven only in REQ so it idles at zero everywhere else.
   always_comb begin
      mem_req   = (state == REQ);
      mem_we    = mem_req && is_store_r;
      mem_addr  = mem_req ? addr_word : '0;
      mem_be    = mem_req ? be_r : 4'b0000;
      mem_wdata = mem_req ? wdata_r : '0;
   end

   assign rsp_valid      = (state == RESP);
   assign rsp_rdata      = rdata_r;
   assign rsp_rd         = rd_r;
   assign rsp_misaligned = misaligned_r;
   assign rsp_illegal    = illegal_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized requests
// checked against an arithmetic reference model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        rsp_valid, rsp_ready, rsp_misaligned, rsp_illegal;
   logic [31:0] rsp_rdata;
   logic [4:0]  rsp_rd;

   int total = 0;
   int bad   = 0;

   load_store_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_is_store   (req_is_store),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_rd         (req_rd),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_be         (mem_be),
      .mem_wdata      (mem_wdata),
      .mem_gnt        (mem_gnt),
      .mem_rvalid     (mem_rvalid),
      .mem_rdata      (mem_rdata),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_rdata      (rsp_rdata),
      .rsp_rd         (rsp_rd),
      .rsp_misaligned (rsp_misaligned),
      .rsp_illegal    (rsp_illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: access size, fault rules and extension by plain arithmetic.
   function automatic void model(input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, wd, rword,
                                 output logic ill, output logic mis,
                                 output logic [3:0] be, output logic [31:0] mwd,
                                 output logic [31:0] res);
      int size, off;
      longint v, lim;
      ill  = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (st && f3 >= 3'd4);
      size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
      off  = int'(addr % 4);
      mis  = !ill && (off % size != 0);
      be   = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if (i >= off && i < off + size) be[i] = 1'b1;
         mwd[8*i +: 8] = wd[8*(i % size) +: 8];
      end
      lim = longint'(1) << (8 * size);
      v   = (longint'(rword) >> (8 * off)) % lim;
      if ((f3 == 3'd0 || f3 == 3'd1) && v >= lim / 2) v = v - lim;
      res = v[31:0];
      if (st || ill || mis) res = 32'd0;
   endfunction

   // One complete request; entered and left at a negedge with the unit idle.
   task automatic do_op(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rword, input logic [4:0] rd,
                        input int gdly, input int vdly, input int rdly);
      logic ill, mis;
      logic [3:0] be;
      logic [31:0] mwd, res;
      model(st, f3, addr, wd, rword, ill, mis, be, mwd, res);
      check({tag, " req_ready idle"}, req_ready, 1);
      req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
      req_addr = addr; req_wdata = wd; req_rd = rd;
      @(negedge clk);
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
      if (!(ill || mis)) begin
         for (int i = 0; i <= gdly; i++) begin
            check({tag, " mem_req"}, mem_req, 1);
            check({tag, " mem_we"}, mem_we, st);
            check({tag, " mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
            check({tag, " mem_be"}, mem_be, be);
            if (st) check({tag, " mem_wdata"}, mem_wdata, mwd);
            check({tag, " rsp_valid in req"}, rsp_valid, 0);
            check({tag, " req_ready busy"}, req_ready, 0);
            mem_gnt    = (i == gdly);
            mem_rvalid = (!st && i < gdly);  // stray rvalid while not waiting
            mem_rdata  = $urandom;
            @(negedge clk);
         end
         mem_gnt = 1'b0; mem_rvalid = 1'b0;
         if (!st) begin
            for (int i = 1; i <= vdly; i++) begin
               check({tag, " mem_req in wait"}, mem_req, 0);
               check({tag, " rsp_valid in wait"}, rsp_valid, 0);
               mem_rvalid = (i == vdly);
               mem_rdata  = (i == vdly) ? rword : $urandom;
               @(negedge clk);
            end
            mem_rvalid = 1'b0; mem_rdata = $urandom;
         end
      end
      for (int i = 0; i <= rdly; i++) begin
         check({tag, " rsp_valid"}, rsp_valid, 1);
         check({tag, " rsp_rdata"}, rsp_rdata, res);
         check({tag, " rsp_rd"}, rsp_rd, rd);
         check({tag, " rsp_misaligned"}, rsp_misaligned, mis);
         check({tag, " rsp_illegal"}, rsp_illegal, ill);
         check({tag, " req_ready in resp"}, req_ready, 0);
         check({tag, " mem_req in resp"}, mem_req, 0);
         rsp_ready = (i == rdly);
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      check({tag, " rsp_valid after"}, rsp_valid, 0);
      check({tag, " req_ready after"}, req_ready, 1);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; rsp_ready = 1'b0;

      // Reset state
      #12;
      check("rst mem_req", mem_req, 0);
      check("rst mem_we", mem_we, 0);
      check("rst mem_be", mem_be, 0);
      check("rst mem_addr", mem_addr, 0);
      check("rst mem_wdata", mem_wdata, 0);
      check("rst rsp_valid", rsp_valid, 0);
      check("rst rsp_rdata", rsp_rdata, 0);
      check("rst rsp_rd", rsp_rd, 0);
      check("rst rsp_misaligned", rsp_misaligned, 0);
      check("rst rsp_illegal", rsp_illegal, 0);
      check("rst req_ready", req_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("post-rst req_ready", req_ready, 1);
      @(negedge clk);

      // Directed cases
      do_op("lb",  1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h8000_0000, 5'd3, 0, 1, 0);
      do_op("lbu", 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h8000_0000, 5'd4, 0, 1, 0);
      do_op("sh",  1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 5'd5, 0, 1, 0);
      do_op("lw misaligned", 1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'h0, 5'd6, 0, 1, 0);
      do_op("f3 011 illegal", 1'b0, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 5'd7, 0, 1, 0);
      do_op("sbu illegal", 1'b1, 3'b100, 32'h0000_3001, 32'h55, 32'h0, 5'd8, 0, 1, 0);
      do_op("ill over mis", 1'b0, 3'b111, 32'h0000_3003, 32'h0, 32'h0, 5'd9, 0, 1, 0);
      do_op("lh stall", 1'b0, 3'b001, 32'h0000_4002, 32'h0, 32'h7FFF_0000, 5'd10, 3, 2, 0);
      do_op("sw hold", 1'b1, 3'b010, 32'h0000_5004, 32'hCAFE_F00D, 32'h0, 5'd11, 1, 1, 4);
      do_op("lhu b2b", 1'b0, 3'b101, 32'h0000_5006, 32'h0, 32'h8001_1234, 5'd12, 0, 1, 0);
      do_op("lw b2b", 1'b0, 3'b010, 32'h0000_5008, 32'h0, 32'h89AB_CDEF, 5'd13, 0, 3, 1);

      // Reset while in REQ drops mem_req asynchronously
      req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
      req_addr = 32'h0000_6000; req_rd = 5'd14;
      @(negedge clk);
      req_valid = 1'b0;
      check("rst-in-req mem_req before", mem_req, 1);
      #2 rst_n = 1'b0;
      #1 check("rst-in-req mem_req", mem_req, 0);
      check("rst-in-req mem_be", mem_be, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset while in WAIT, then a stray rvalid must not produce a response
      req_valid = 1'b1; req_funct3 = 3'b000; req_addr = 32'h0000_7001; req_rd = 5'd15;
      @(negedge clk);
      req_valid = 1'b0; mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      #2 rst_n = 1'b0;
      #1 check("rst-in-wait mem_req", mem_req, 0);
      check("rst-in-wait rsp_valid", rsp_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("stray rvalid rsp_valid", rsp_valid, 0);
         check("stray rvalid req_ready", req_ready, 1);
         @(negedge clk);
      end

      // Reset while in RESP drops rsp_valid asynchronously
      req_valid = 1'b1; req_funct3 = 3'b110; req_addr = 32'h0; req_rd = 5'd16;
      @(negedge clk);
      req_valid = 1'b0;
      check("rst-in-resp rsp_valid before", rsp_valid, 1);
      #2 rst_n = 1'b0;
      #1 check("rst-in-resp rsp_valid", rsp_valid, 0);
      check("rst-in-resp rsp_illegal", rsp_illegal, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_op("after rst", 1'b0, 3'b001, 32'h0000_8000, 32'h0, 32'h0000_8765, 5'd17, 0, 1, 0);

      // Randomized requests
      for (int n = 0; n < 60; n++) begin
         logic        st;
         logic [2:0]  f3;
         logic [31:0] addr;
         st   = 1'($urandom_range(0, 1));
         f3   = 3'($urandom_range(0, 7));
         addr = $urandom;
         if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
         do_op("rand", st, f3, addr, $urandom, $urandom, 5'($urandom),
               $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
